// File: rtl/i2c_slave_target_if.sv
// Bus-side and core-side signals of the I2C target, grouped for port connection.
// The slave modport is the target's view; master is the view of whoever drives the pins and core.
interface i2c_slave_target_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       rw;
    logic       busy;
    logic       nack_rx;

    modport slave (
        input  scl_i, sda_i, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, rw, busy, nack_rx
    );

    modport master (
        output scl_i, sda_i, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, rw, busy, nack_rx
    );
endinterface

// File: rtl/i2c_slave_target.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, single 7-bit address,
// write bytes delivered to the core, read bytes serialised from it. SDA is open-drain.
module i2c_slave_target #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    i2c_slave_target_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ACK_ADDR, WRITE, ACK_WRITE, READ, ACK_READ} state_t;

    state_t state, state_d;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic s_scl, s_sda, p_scl, p_sda;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [2:0] cnt, cnt_d;
    logic [6:0] sr, sr_d;
    logic [7:0] tx_sr, tx_d, rx_q, rx_d, byte_in;
    logic oe_q, oe_d, rw_q, rw_d;
    logic rx_v_q, rx_v_d, tx_req_q, tx_req_d, nack_q, nack_d;

    // Synchronisers idle high so releasing reset on a quiet bus never looks like a START.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            p_scl    <= 1'b1;
            p_sda    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_i};
            p_scl    <= s_scl;
            p_sda    <= s_sda;
        end
    end

    assign s_scl     = scl_sync[SYNC_STAGES-1];
    assign s_sda     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = s_scl & ~p_scl;
    assign scl_fall  = ~s_scl & p_scl;
    assign start_det = s_scl & p_scl & p_sda & ~s_sda;
    assign stop_det  = s_scl & p_scl & ~p_sda & s_sda;
    assign byte_in   = {sr, s_sda};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            sr       <= '0;
            tx_sr    <= '0;
            rx_q     <= '0;
            oe_q     <= 1'b0;
            rw_q     <= 1'b0;
            rx_v_q   <= 1'b0;
            tx_req_q <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            sr       <= sr_d;
            tx_sr    <= tx_d;
            rx_q     <= rx_d;
            oe_q     <= oe_d;
            rw_q     <= rw_d;
            rx_v_q   <= rx_v_d;
            tx_req_q <= tx_req_d;
            nack_q   <= nack_d;
        end
    end

    // In the ACK states cnt[0] marks that the first SCL event of the ACK slot has passed.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        sr_d     = sr;
        tx_d     = tx_sr;
        rx_d     = rx_q;
        oe_d     = oe_q;
        rw_d     = rw_q;
        rx_v_d   = 1'b0;
        tx_req_d = 1'b0;
        nack_d   = 1'b0;
        if (start_det) begin
            state_d = ADDR;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else if (stop_det) begin
            state_d = IDLE;
            cnt_d   = '0;
            oe_d    = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    sr_d  = byte_in[6:0];
                    cnt_d = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        if (byte_in[7:1] == SLAVE_ADDR) begin
                            rw_d    = byte_in[0];
                            state_d = ACK_ADDR;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                ACK_ADDR: begin
                    if (scl_fall) begin
                        if (!cnt[0]) begin
                            oe_d  = 1'b1;
                            cnt_d = 3'd1;
                        end else if (rw_q) begin
                            tx_d    = bus.tx_data;
                            oe_d    = ~bus.tx_data[7];
                            cnt_d   = '0;
                            state_d = READ;
                        end else begin
                            oe_d    = 1'b0;
                            cnt_d   = '0;
                            state_d = WRITE;
                        end
                    end else if (scl_rise && cnt[0] && rw_q) begin
                        tx_req_d = 1'b1;
                    end
                end
                WRITE: if (scl_rise) begin
                    sr_d  = byte_in[6:0];
                    cnt_d = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        rx_d    = byte_in;
                        rx_v_d  = 1'b1;
                        state_d = ACK_WRITE;
                    end
                end
                ACK_WRITE: if (scl_fall) begin
                    if (!cnt[0]) begin
                        oe_d  = 1'b1;
                        cnt_d = 3'd1;
                    end else begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = WRITE;
                    end
                end
                // cnt counts SCL falls here; the fall after the 8th bit hands SDA back for the ACK.
                READ: if (scl_fall) begin
                    if (cnt == 3'd7) begin
                        oe_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = ACK_READ;
                    end else begin
                        tx_d  = {tx_sr[6:0], tx_sr[7]};
                        oe_d  = ~tx_sr[6];
                        cnt_d = cnt + 3'd1;
                    end
                end
                ACK_READ: begin
                    if (scl_rise && !cnt[0]) begin
                        if (!s_sda) begin
                            tx_req_d = 1'b1;
                            cnt_d    = 3'd1;
                        end else begin
                            nack_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (scl_fall && cnt[0]) begin
                        tx_d    = bus.tx_data;
                        oe_d    = ~bus.tx_data[7];
                        cnt_d   = '0;
                        state_d = READ;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe   = oe_q;
    assign bus.rx_data  = rx_q;
    assign bus.rx_valid = rx_v_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.rw       = rw_q;
    assign bus.busy     = (state != IDLE);
    assign bus.nack_rx  = nack_q;
endmodule

// File: tb/tb_i2c_slave_target.sv
// Bench for i2c_slave_target: bit-level I2C master, transaction-level model of the target,
// per-cycle compare of the outputs in each SCL-high window, directed cases plus random traffic.
module tb_i2c_slave_target;
    localparam logic [6:0] ADDR = 7'h50;
    localparam logic [7:0] AW   = {ADDR, 1'b0};
    localparam logic [7:0] AR   = {ADDR, 1'b1};
    localparam int         Q    = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl_m = 1'b1, sda_m = 1'b1;
    logic [7:0] tx_data_r = 8'h00;

    i2c_slave_target_if bus();
    assign bus.scl_i   = scl_m;
    assign bus.sda_i   = sda_m & ~bus.sda_oe;
    assign bus.tx_data = tx_data_r;

    i2c_slave_target #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    // Transaction-level model of what the target must do.
    bit m_busy = 0, m_addr_ok = 0, m_rw = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] tx_feed[$];
    logic [7:0] exp_tx[$];
    int exp_rxcnt = 0, exp_txreq = 0, exp_nack = 0;
    int cnt_rx = 0, cnt_txreq = 0, cnt_nack = 0;
    logic exp_oe = 0, exp_busy = 0, chk_en = 0;
    bit oe_seen = 0;
    logic [7:0] last_rx = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: pulses against the model queues, levels inside SCL-high windows.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                if (bus.sda_oe) oe_seen = 1;
                if (bus.rx_valid) begin
                    cnt_rx++;
                    last_rx = bus.rx_data;
                    chk("rx_valid_expected", exp_rx.size() > 0, 1);
                    if (exp_rx.size() > 0) chk("rx_data", bus.rx_data, exp_rx.pop_front());
                end
                if (bus.tx_req) begin
                    cnt_txreq++;
                    if (tx_feed.size() > 0) tx_data_r = tx_feed.pop_front();
                    else tx_data_r = 8'hEE;
                end
                if (bus.nack_rx) cnt_nack++;
                if (chk_en) begin
                    chk("sda_oe", bus.sda_oe, exp_oe);
                    chk("busy", bus.busy, exp_busy);
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic eoe, input logic ebusy, output logic s);
        sda_m = b;
        clk_n(Q);
        scl_m = 1'b1;
        exp_oe = eoe;
        exp_busy = ebusy;
        clk_n(Q);
        chk_en = 1'b1;
        clk_n(Q);
        chk_en = 1'b0;
        s = bus.sda_i;
        scl_m = 1'b0;
        clk_n(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; clk_n(Q);
        scl_m = 1'b1; clk_n(Q);
        sda_m = 1'b0; clk_n(Q);
        chk("start_busy", bus.busy, 1);
        chk("start_oe", bus.sda_oe, 0);
        scl_m = 1'b0; clk_n(Q);
        m_busy = 1; m_addr_ok = 0;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; clk_n(Q);
        scl_m = 1'b1; clk_n(Q);
        sda_m = 1'b1; clk_n(2*Q);
        chk("stop_busy", bus.busy, 0);
        chk("stop_oe", bus.sda_oe, 0);
        m_busy = 0; m_addr_ok = 0;
    endtask

    task automatic wr_byte(input logic [7:0] b, input bit is_addr);
        logic s;
        logic eb;
        bit match;
        match = is_addr && (b[7:1] == ADDR);
        if (!is_addr && m_addr_ok && !m_rw) begin
            exp_rx.push_back(b);
            exp_rxcnt++;
        end
        for (int i = 0; i < 8; i++) begin
            eb = m_busy;
            if (is_addr && i == 7) eb = match;
            send_bit(b[7-i], 1'b0, eb, s);
        end
        if (is_addr) begin
            m_addr_ok = match;
            m_busy = match;
            if (match) begin
                m_rw = b[0];
                if (b[0]) exp_txreq++;
            end
        end
        send_bit(1'b1, m_addr_ok, m_busy, s);
        if (is_addr && match) chk("rw", bus.rw, b[0]);
    endtask

    task automatic plan_tx(input logic [7:0] b);
        tx_feed.push_back(b);
        exp_tx.push_back(b);
    endtask

    task automatic rd_byte(input bit ack, output logic [7:0] got);
        logic s;
        logic [7:0] e;
        e = exp_tx.pop_front();
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, ~e[7-i], 1'b1, s);
            got[7-i] = s;
        end
        chk("rd_byte", got, e);
        send_bit(~ack, 1'b0, ack, s);
        if (ack) exp_txreq++;
        else begin
            exp_nack++;
            m_busy = 0;
            m_addr_ok = 0;
        end
    endtask

    initial begin
        logic [7:0] g0, g1;
        logic [6:0] a;
        logic s;
        int k, n, snap_rx, snap_tx, snap_nk;

        clk_n(5);
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_tx_req", bus.tx_req, 0);
        chk("rst_rw", bus.rw, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_nack_rx", bus.nack_rx, 0);
        reset = 1'b0;
        clk_n(10);
        chk("idle_busy", bus.busy, 0);

        // Write 0xA5
        snap_rx = cnt_rx; oe_seen = 0;
        i2c_start(); wr_byte(AW, 1); wr_byte(8'hA5, 0); i2c_stop();
        chk("wr_rx_count", cnt_rx - snap_rx, 1);
        chk("wr_rx_data_lit", last_rx, 8'hA5);
        chk("wr_oe_seen", oe_seen, 1);

        // Address mismatch
        snap_rx = cnt_rx; oe_seen = 0;
        i2c_start(); wr_byte(8'hA2, 1); wr_byte(8'h11, 0);
        chk("mm_oe_never", oe_seen, 0);
        chk("mm_busy", bus.busy, 0);
        chk("mm_rx_count", cnt_rx - snap_rx, 0);
        i2c_stop();

        // Read 0x3C then 0xC3, ACK then NACK
        snap_tx = cnt_txreq; snap_nk = cnt_nack;
        plan_tx(8'h3C); plan_tx(8'hC3);
        i2c_start(); wr_byte(AR, 1);
        rd_byte(1, g0); rd_byte(0, g1);
        chk("rd_lit0", g0, 8'h3C);
        chk("rd_lit1", g1, 8'hC3);
        chk("rd_txreq", cnt_txreq - snap_tx, 2);
        chk("rd_nack", cnt_nack - snap_nk, 1);
        chk("rd_idle", bus.busy, 0);
        i2c_stop();

        // Write, repeated START, read
        snap_rx = cnt_rx;
        i2c_start(); wr_byte(AW, 1); wr_byte(8'h12, 0);
        plan_tx(8'h96);
        i2c_start(); wr_byte(AR, 1);
        chk("sr_rw", bus.rw, 1);
        rd_byte(0, g0);
        i2c_stop();
        chk("sr_rx_count", cnt_rx - snap_rx, 1);
        chk("sr_rx_lit", last_rx, 8'h12);

        // STOP after 4 data bits
        snap_rx = cnt_rx;
        i2c_start(); wr_byte(AW, 1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b1, s);
        i2c_stop();
        chk("ps_rx_count", cnt_rx - snap_rx, 0);

        // Reset while ACKing the address
        snap_rx = cnt_rx;
        i2c_start();
        for (int i = 0; i < 8; i++) send_bit(AW[7-i], 1'b0, 1'b1, s);
        sda_m = 1'b1; clk_n(Q);
        scl_m = 1'b1; clk_n(Q);
        chk("ack_oe_pre_reset", bus.sda_oe, 1);
        #3 reset = 1'b1;
        #1 chk("reset_oe_async", bus.sda_oe, 0);
        m_busy = 0; m_addr_ok = 0;
        clk_n(3);
        reset = 1'b0;
        clk_n(30);
        chk("post_reset_busy", bus.busy, 0);
        chk("post_reset_oe", bus.sda_oe, 0);
        chk("post_reset_rx_data", bus.rx_data, 0);
        chk("post_reset_rx_count", cnt_rx - snap_rx, 0);

        // Random traffic
        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 4))
                0: begin
                    k = $urandom_range(1, 3);
                    i2c_start(); wr_byte(AW, 1);
                    for (int j = 0; j < k; j++) wr_byte(8'($urandom), 0);
                    i2c_stop();
                end
                1: begin
                    a = 7'($urandom);
                    if (a == ADDR) a = a ^ 7'h01;
                    i2c_start(); wr_byte({a, 1'($urandom)}, 1); wr_byte(8'($urandom), 0);
                    i2c_stop();
                end
                2: begin
                    k = $urandom_range(1, 3);
                    for (int j = 0; j < k; j++) plan_tx(8'($urandom));
                    i2c_start(); wr_byte(AR, 1);
                    for (int j = 0; j < k; j++) rd_byte(j != k - 1, g0);
                    i2c_stop();
                end
                3: begin
                    plan_tx(8'($urandom));
                    i2c_start(); wr_byte(AW, 1); wr_byte(8'($urandom), 0);
                    i2c_start(); wr_byte(AR, 1); rd_byte(0, g0);
                    i2c_stop();
                end
                default: begin
                    n = $urandom_range(1, 6);
                    i2c_start(); wr_byte(AW, 1);
                    for (int j = 0; j < n; j++) send_bit(1'($urandom), 1'b0, 1'b1, s);
                    if ($urandom_range(0, 1) == 1) begin
                        i2c_start(); wr_byte(AW, 1); wr_byte(8'($urandom), 0);
                    end
                    i2c_stop();
                end
            endcase
        end

        clk_n(10);
        chk("total_rx", cnt_rx, exp_rxcnt);
        chk("rx_queue_drained", exp_rx.size(), 0);
        chk("total_txreq", cnt_txreq, exp_txreq);
        chk("total_nack", cnt_nack, exp_nack);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
